// File: rtl/sha256_round_ctrl.sv
// Control sequencer for one SHA-256 compression datapath: message load, K streaming,
// 64 rounds, hash update and digest handoff, chained across blocks until the last one.
module sha256_round_ctrl #(
  parameter int unsigned NUM_ROUNDS      = 64,
  parameter int unsigned WORDS_PER_BLOCK = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             msg_valid,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic             w_load,
  output logic [3:0]       w_idx,
  output logic             hash_init,
  output logic             ena_K_reg,
  output logic             round_en,
  output logic [5:0]       round_idx,
  output logic             w_from_msg,
  output logic             hash_update,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_WORD  = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [5:0] MSG_ROUNDS = 6'(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PRIME  = 3'd2,
    ROUND  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [3:0]       w_idx_n;
  logic [5:0]       round_idx_n;
  logic [CNT_W-1:0] blk_count_n;
  logic             last_flag, last_flag_n;

  // Next state and counters; abort overrides every normal transition.
  always_comb begin
    state_n     = state;
    w_idx_n     = w_idx;
    round_idx_n = round_idx;
    blk_count_n = blk_count;
    last_flag_n = last_flag;
    if (abort) begin
      state_n     = IDLE;
      w_idx_n     = 4'd0;
      round_idx_n = 6'd0;
      blk_count_n = '0;
      last_flag_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n     = LOAD;
            w_idx_n     = 4'd0;
            blk_count_n = '0;
          end
        end
        LOAD: begin
          if (msg_valid) begin
            if (w_idx == LAST_WORD) begin
              w_idx_n     = 4'd0;
              last_flag_n = msg_last;
              state_n     = PRIME;
            end else begin
              w_idx_n = w_idx + 4'd1;
            end
          end
        end
        PRIME: begin
          round_idx_n = 6'd0;
          state_n     = ROUND;
        end
        ROUND: begin
          if (round_idx == LAST_ROUND) begin
            round_idx_n = 6'd0;
            state_n     = UPDATE;
          end else begin
            round_idx_n = round_idx + 6'd1;
          end
        end
        UPDATE: begin
          blk_count_n = blk_count + CNT_W'(1);
          state_n     = last_flag ? DONE : LOAD;
        end
        DONE: begin
          if (digest_ready) begin
            last_flag_n = 1'b0;
            state_n     = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      w_idx        <= 4'd0;
      round_idx    <= 6'd0;
      blk_count    <= '0;
      last_flag    <= 1'b0;
      msg_ready    <= 1'b0;
      hash_init    <= 1'b0;
      ena_K_reg    <= 1'b0;
      round_en     <= 1'b0;
      w_from_msg   <= 1'b0;
      hash_update  <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      w_idx        <= w_idx_n;
      round_idx    <= round_idx_n;
      blk_count    <= blk_count_n;
      last_flag    <= last_flag_n;
      msg_ready    <= (state_n == LOAD);
      hash_init    <= (state == IDLE) && (state_n == LOAD);
      // K_register clears its counter when enable drops, so keep it high PRIME through round 63
      ena_K_reg    <= (state_n == PRIME) || (state_n == ROUND);
      round_en     <= (state_n == ROUND);
      w_from_msg   <= (state_n == ROUND) && (round_idx_n < MSG_ROUNDS);
      hash_update  <= (state_n == UPDATE);
      digest_valid <= (state_n == DONE);
      busy         <= (state_n != IDLE);
    end
  end

  assign w_load = msg_valid & msg_ready;

endmodule
